// File: rtl/nios_led_oci_trace_pkg.sv
// Shared encodings and width helpers for the OCI trace monitor.
package nios_led_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic int unsigned entry_w(input int unsigned cnt_w, input int unsigned data_w);
    return cnt_w + data_w;
  endfunction

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nios_led_oci_trace_ring.sv
// Circular trace buffer; occupancy tracked by an explicit level counter.
module nios_led_oci_trace_ring
  import nios_led_oci_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENTRY_W = 34
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic                        overwrite_oldest,
  input  logic                        pop,
  input  logic [ENTRY_W-1:0]          wdata,
  output logic [ENTRY_W-1:0]          rdata_c,
  output logic [level_w(DEPTH)-1:0]   fill_level,
  output logic                        full_c,
  output logic                        empty_c
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               add_c;
  logic               ovw_c;
  logic               del_c;

  assign full_c  = (fill_level == LVL_W'(DEPTH));
  assign empty_c = (fill_level == '0);
  assign add_c   = push && !full_c;
  assign ovw_c   = overwrite_oldest && full_c;
  assign del_c   = pop && !empty_c;
  assign rdata_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (add_c || ovw_c) mem[wr_ptr] <= wdata;
  end

  // An overwrite advances both pointers so the oldest entry is retired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (add_c || ovw_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (ovw_c || del_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({add_c, del_c})
        2'b10:   fill_level <= fill_level + LVL_W'(1);
        2'b01:   fill_level <= fill_level - LVL_W'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

endmodule

// File: rtl/nios_led_cpu_oci_trace_monitor.sv
// Captures OCI debug-trace entries on count change, then drains them on test end.
module nios_led_cpu_oci_trace_monitor
  import nios_led_oci_trace_pkg::*;
#(
  parameter int unsigned DATA_W    = 30,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WRAP_MODE = 1,
  parameter int unsigned DROP_W    = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [DATA_W-1:0]                   dct_buffer,
  input  logic [CNT_W-1:0]                    dct_count,
  input  logic                                test_ending,
  input  logic                                test_has_ended,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [entry_w(CNT_W, DATA_W)-1:0]   rd_data,
  output logic [level_w(DEPTH)-1:0]           fill_level,
  output logic                                overflow,
  output logic [DROP_W-1:0]                   drop_count,
  output logic [1:0]                          state_o,
  output logic                                done
);

  localparam int unsigned ENTRY_W = entry_w(CNT_W, DATA_W);
  localparam bit          WRAP    = (WRAP_MODE != 0);

  state_e             state;
  logic [CNT_W-1:0]   prev_count;
  logic               push_c;
  logic               pop_c;
  logic               drop_c;
  logic               full_c;
  logic               empty_c;
  logic [ENTRY_W-1:0] head_c;

  assign push_c   = (dct_count != prev_count) && (state == ST_CAPTURE);
  assign drop_c   = push_c && full_c;
  assign rd_valid = (state == ST_DRAIN) && !empty_c;
  assign pop_c    = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? head_c : '0;
  assign state_o  = state;

  nios_led_oci_trace_ring #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ring (
    .clk              (clk),
    .reset_n          (reset_n),
    .push             (push_c),
    .overwrite_oldest (push_c && WRAP),
    .pop              (pop_c),
    .wdata            ({dct_count, dct_buffer}),
    .rdata_c          (head_c),
    .fill_level       (fill_level),
    .full_c           (full_c),
    .empty_c          (empty_c)
  );

  // DONE waits on the registered level, so the last pop lands before the exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CAPTURE;
      prev_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      done       <= 1'b0;
    end else begin
      prev_count <= dct_count;
      if (drop_c) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
      end
      case (state)
        ST_CAPTURE: if (test_ending || test_has_ended) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (test_has_ended && empty_c) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_CAPTURE;
      endcase
    end
  end

endmodule
